// File: rtl/scalar_tuple_serializer.sv
// ----------------------------------------------------------------------------
// scalar_tuple_serializer
//
// Takes one 10-field scalar tuple (field widths 3,4,4,4,3,3,2,2,3,3) from the
// tuple producer and replays it field by field on a narrow valid/ready stream
// for the debug/trace sink. Each beat carries the zero-extended field value,
// its 1-based field index and a last flag. With SKIP_ZERO=1, zero-valued
// fields 1..9 are not sent; field 10 always is, so every tuple ends with a
// beat at index 10.
//
// Ports
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low
//   in_valid   in   1      tuple on in_f1..in_f10 is valid
//   in_ready   out  1      a tuple is accepted this cycle
//   in_f1..10  in   var    tuple fields (3,4,4,4,3,3,2,2,3,3 bits)
//   out_valid  out  1      beat valid
//   out_ready  in   1      sink accepts the beat
//   out_data   out  OUT_W  field value, zero-extended
//   out_idx    out  IDX_W  field index 1..10
//   out_last   out  1      final beat of the tuple
//   busy       out  1      a tuple is held and being sent
//   tuple_cnt  out  CNT_W  completed tuples, wrapping
// ----------------------------------------------------------------------------
module scalar_tuple_serializer #(
    parameter int          OUT_W     = 4,
    parameter int          IDX_W     = 4,
    parameter int          CNT_W     = 8,
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_f1,
    input  logic [3:0]       in_f2,
    input  logic [3:0]       in_f3,
    input  logic [3:0]       in_f4,
    input  logic [2:0]       in_f5,
    input  logic [2:0]       in_f6,
    input  logic [1:0]       in_f7,
    input  logic [1:0]       in_f8,
    input  logic [2:0]       in_f9,
    input  logic [2:0]       in_f10,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] tuple_cnt
);

    localparam int NFLD = 10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] sh_q [NFLD];
    logic             load;

    logic [OUT_W-1:0] in_fld [NFLD];
    logic [8:0]       in_mask;
    logic [8:0]       sh_mask;
    logic             beat_acc;

    // Smallest field index greater than cur among fields 1..9 whose mask bit
    // is set; falls through to field 10, which is always sent.
    function automatic logic [IDX_W-1:0] first_after(input logic [8:0]       mask,
                                                     input logic [IDX_W-1:0] cur);
        logic [IDX_W-1:0] r;
        logic             found;
        r     = IDX_W'(NFLD);
        found = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (!found && (IDX_W'(k) > cur) && mask[k-1]) begin
                r     = IDX_W'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Zero-extend the incoming fields into one uniform array.
    always_comb begin
        in_fld[0] = OUT_W'(in_f1);
        in_fld[1] = OUT_W'(in_f2);
        in_fld[2] = OUT_W'(in_f3);
        in_fld[3] = OUT_W'(in_f4);
        in_fld[4] = OUT_W'(in_f5);
        in_fld[5] = OUT_W'(in_f6);
        in_fld[6] = OUT_W'(in_f7);
        in_fld[7] = OUT_W'(in_f8);
        in_fld[8] = OUT_W'(in_f9);
        in_fld[9] = OUT_W'(in_f10);
    end

    // Send-eligibility masks for fields 1..9. Without skipping, every field
    // is eligible, so the search degenerates to cur+1.
    always_comb begin
        in_mask = '0;
        sh_mask = '0;
        for (int k = 0; k < 9; k++) begin
            in_mask[k] = (SKIP_ZERO == 0) || (in_fld[k] != '0);
            sh_mask[k] = (SKIP_ZERO == 0) || (sh_q[k] != '0);
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_W'(1);
            cnt_q   <= '0;
            for (int k = 0; k < NFLD; k++) begin
                sh_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (load) begin
                for (int k = 0; k < NFLD; k++) begin
                    sh_q[k] <= in_fld[k];
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = first_after(in_mask, '0);
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (beat_acc) begin
                    if (!out_last) begin
                        idx_d = first_after(sh_mask, idx_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        // A waiting tuple is taken in the same cycle as the
                        // last beat, so consecutive tuples have no bubble.
                        if (in_valid) begin
                            load  = 1'b1;
                            idx_d = first_after(in_mask, '0);
                        end else begin
                            idx_d   = IDX_W'(1);
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = IDX_W'(1);
            end
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == S_SEND);
        busy      = (state_q == S_SEND);
        out_last  = (state_q == S_SEND) && (idx_q == IDX_W'(NFLD));
        out_idx   = idx_q;
        tuple_cnt = cnt_q;
        out_data  = '0;
        for (int k = 0; k < NFLD; k++) begin
            if (idx_q == IDX_W'(k + 1)) begin
                out_data = sh_q[k];
            end
        end
        // reset gates in_ready directly so nothing is accepted while it is low.
        in_ready = reset && ((state_q == S_IDLE) ||
                             ((state_q == S_SEND) && out_last && out_ready));
        beat_acc = out_valid && out_ready;
    end

endmodule

// File: tb/tb_scalar_tuple_serializer.sv
module tb_scalar_tuple_serializer;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] f1, f5, f6, f9, f10;
    logic [3:0] f2, f3, f4;
    logic [1:0] f7, f8;

    // Default instance
    logic       o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [3:0] o_out_data, o_out_idx;
    logic [7:0] o_tuple_cnt;
    // SKIP_ZERO=1 instance
    logic       s_in_ready, s_out_valid, s_out_last, s_busy;
    logic [3:0] s_out_data, s_out_idx;
    logic [7:0] s_tuple_cnt;
    // CNT_W=2 instance
    logic       c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [3:0] c_out_data, c_out_idx;
    logic [1:0] c_tuple_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned ta [10] = '{7, 8, 9, 10, 7, 6, 3, 3, 7, 5};
    int unsigned tb [10] = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4};
    int unsigned tz [10] = '{0, 8, 0, 0, 7, 0, 0, 3, 0, 0};
    int unsigned t0 [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    scalar_tuple_serializer u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(o_in_ready),
        .in_f1(f1), .in_f2(f2), .in_f3(f3), .in_f4(f4), .in_f5(f5),
        .in_f6(f6), .in_f7(f7), .in_f8(f8), .in_f9(f9), .in_f10(f10),
        .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
        .out_idx(o_out_idx), .out_last(o_out_last), .busy(o_busy),
        .tuple_cnt(o_tuple_cnt)
    );

    scalar_tuple_serializer #(.SKIP_ZERO(1)) u_skip (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_f1(f1), .in_f2(f2), .in_f3(f3), .in_f4(f4), .in_f5(f5),
        .in_f6(f6), .in_f7(f7), .in_f8(f8), .in_f9(f9), .in_f10(f10),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_idx(s_out_idx), .out_last(s_out_last), .busy(s_busy),
        .tuple_cnt(s_tuple_cnt)
    );

    scalar_tuple_serializer #(.CNT_W(2)) u_cnt2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_f1(f1), .in_f2(f2), .in_f3(f3), .in_f4(f4), .in_f5(f5),
        .in_f6(f6), .in_f7(f7), .in_f8(f8), .in_f9(f9), .in_f10(f10),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_idx(c_out_idx), .out_last(c_out_last), .busy(c_busy),
        .tuple_cnt(c_tuple_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fields(input int unsigned f [10]);
        f1  = 3'(f[0]); f2 = 4'(f[1]); f3 = 4'(f[2]); f4 = 4'(f[3]);
        f5  = 3'(f[4]); f6 = 3'(f[5]); f7 = 2'(f[6]); f8 = 2'(f[7]);
        f9  = 3'(f[8]); f10 = 3'(f[9]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;   // must be ignored while reset is low
        out_ready = 1'b0;
        set_fields(ta);
        tick();
        tick();

        // Reset state
        check("rst_in_ready", o_in_ready, 0);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_idx", o_out_idx, 1);
        check("rst_cnt", o_tuple_cnt, 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("idle_in_ready", o_in_ready, 1);
        check("idle_out_valid", o_out_valid, 0);

        // T1: single tuple, sink always ready
        set_fields(ta);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            check($sformatf("t1_valid_%0d", b), o_out_valid, 1);
            check($sformatf("t1_busy_%0d", b), o_busy, 1);
            check($sformatf("t1_data_%0d", b), o_out_data, ta[b]);
            check($sformatf("t1_idx_%0d", b), o_out_idx, b + 1);
            check($sformatf("t1_last_%0d", b), o_out_last, (b == 9));
            check($sformatf("t1_inrdy_%0d", b), o_in_ready, (b == 9));
            tick();
        end
        check("t1_done_valid", o_out_valid, 0);
        check("t1_cnt", o_tuple_cnt, 1);

        // T2: sink stalls every other cycle; each beat held across its stall
        set_fields(ta);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c % 2 == 1);
            #1;
            check($sformatf("t2_valid_%0d", c), o_out_valid, 1);
            check($sformatf("t2_data_%0d", c), o_out_data, ta[c / 2]);
            check($sformatf("t2_idx_%0d", c), o_out_idx, c / 2 + 1);
            check($sformatf("t2_last_%0d", c), o_out_last, (c / 2 == 9));
            tick();
        end
        check("t2_done_valid", o_out_valid, 0);
        check("t2_cnt", o_tuple_cnt, 2);

        // T3: two tuples back to back; second tuple presented while the
        // first is being sent must not disturb it
        do_reset();
        out_ready = 1'b1;
        set_fields(ta);
        in_valid = 1'b1;
        tick();
        set_fields(tb);
        for (int b = 0; b < 20; b++) begin
            check($sformatf("t3_valid_%0d", b), o_out_valid, 1);
            check($sformatf("t3_data_%0d", b), o_out_data, (b < 10) ? ta[b] : tb[b - 10]);
            check($sformatf("t3_idx_%0d", b), o_out_idx, b % 10 + 1);
            check($sformatf("t3_inrdy_%0d", b), o_in_ready, (b % 10 == 9));
            if (b == 10) begin
                check("t3_cnt_mid", o_tuple_cnt, 1);
                in_valid = 1'b0;
            end
            tick();
        end
        check("t3_done_valid", o_out_valid, 0);
        check("t3_cnt", o_tuple_cnt, 2);

        // T4: zero skipping
        do_reset();
        set_fields(tz);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        begin
            int unsigned ei [4] = '{2, 5, 8, 10};
            int unsigned ed [4] = '{8, 7, 3, 0};
            for (int b = 0; b < 4; b++) begin
                check($sformatf("t4_valid_%0d", b), s_out_valid, 1);
                check($sformatf("t4_idx_%0d", b), s_out_idx, ei[b]);
                check($sformatf("t4_data_%0d", b), s_out_data, ed[b]);
                check($sformatf("t4_last_%0d", b), s_out_last, (b == 3));
                tick();
            end
        end
        check("t4_done_valid", s_out_valid, 0);
        check("t4_cnt", s_tuple_cnt, 1);
        // Unskipped instance still sends all ten fields of the same tuple
        check("t4_noskip_idx", o_out_idx, 5);
        check("t4_noskip_data", o_out_data, 7);

        do_reset();
        set_fields(t0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t4z_valid", s_out_valid, 1);
        check("t4z_idx", s_out_idx, 10);
        check("t4z_data", s_out_data, 0);
        check("t4z_last", s_out_last, 1);
        tick();
        check("t4z_done_valid", s_out_valid, 0);
        check("t4z_cnt", s_tuple_cnt, 1);

        // T5: reset in the middle of a tuple
        do_reset();
        set_fields(ta);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t5_pre_idx", o_out_idx, 4);
        check("t5_pre_valid", o_out_valid, 1);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", o_out_valid, 0);
        check("t5_rst_in_ready", o_in_ready, 0);
        check("t5_rst_busy", o_busy, 0);
        tick();
        reset = 1'b1;
        #1;
        check("t5_rel_in_ready", o_in_ready, 1);
        check("t5_rel_cnt", o_tuple_cnt, 0);
        check("t5_rel_idx", o_out_idx, 1);
        set_fields(tb);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_next_idx", o_out_idx, 1);
        check("t5_next_data", o_out_data, tb[0]);

        // T6: narrow counter wraps
        do_reset();
        set_fields(ta);
        begin
            int unsigned ec [5] = '{1, 2, 3, 0, 1};
            for (int t = 0; t < 5; t++) begin
                in_valid = 1'b1;
                tick();
                in_valid = 1'b0;
                for (int b = 0; b < 10; b++) tick();
                check($sformatf("t6_cnt_%0d", t), c_tuple_cnt, ec[t]);
            end
        end
        check("t6_wide_cnt", o_tuple_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
